ring_scratchpad: RTL

Parametrised circular scratchpad buffer: the next generation of the single-port SRAM plus address-counter pair, with wrap-around pointer management built in. Holds a sliding window of `WIDTH`-bit words for the datapath, accepts streamed writes, serves random reads at an offset from the oldest word, and frees words in bulk (stride release). `DEPTH` need not be a power of two.

---
 rtl/scratch_pkg.sv | 19 +
 rtl/ring_scratchpad_index_add.sv | 25 ++
 rtl/ring_scratchpad.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/scratch_pkg.sv
// Shared constants and width helpers for the ring scratchpad and the address
// generators that drive it.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default word width and storage depth
//   addr_len(depth)               : pointer / offset width for a given depth
//   cnt_w(depth)                  : occupancy counter width (must hold depth)
package scratch_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 16;

    function automatic int addr_len(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ring_scratchpad_index_add.sv
// ring_index_add: combinational modular add, o_sum = (i_base + i_inc) mod DEPTH.
// Both operands are expected to be below DEPTH, so a single conditional
// subtraction of DEPTH brings the sum back into range.
//   i_base : ADDR_LEN  pointer to advance
//   i_inc  : ADDR_LEN  advance amount
//   o_sum  : ADDR_LEN  wrapped result
module ring_index_add #(
    parameter int DEPTH    = 16,
    parameter int ADDR_LEN = 4
) (
    input  logic [ADDR_LEN-1:0] i_base,
    input  logic [ADDR_LEN-1:0] i_inc,
    output logic [ADDR_LEN-1:0] o_sum
);

    localparam logic [ADDR_LEN:0] DEPTH_EXT = (ADDR_LEN + 1)'(DEPTH);

    // One extra bit so the carry out of the add is never lost.
    logic [ADDR_LEN:0] w_sum;

    assign w_sum = {1'b0, i_base} + {1'b0, i_inc};
    assign o_sum = (w_sum >= DEPTH_EXT) ? ADDR_LEN'(w_sum - DEPTH_EXT)
                                        : ADDR_LEN'(w_sum);

endmodule

// File: rtl/ring_scratchpad.sv
// ring_scratchpad: circular scratchpad holding a sliding window of WIDTH-bit
// words. Streamed writes append at the tail, random reads address an offset
// from the oldest word, and bulk release frees words from the head.
// DEPTH need not be a power of two.
//   clk, rst              : clock, asynchronous active-high reset
//   flush                 : synchronous clear of pointers and occupancy
//   wr_valid/wr_data      : append request; wr_ready = !full
//   rd_req/rd_offset      : random read request, offset from oldest word
//   rd_valid/rd_data      : registered read result, one cycle after request
//   rd_err                : one-cycle pulse, previous request was out of range
//   release_en/release_cnt: free min(release_cnt, count) words from the head
//   count/full/empty      : occupancy status
//
// Write handshake: a word is accepted on a rising edge exactly when wr_valid
// and wr_ready are both high; wr_ready depends only on the registered
// occupancy, never on wr_valid. A flush on the same edge drops the word.
module ring_scratchpad
    import scratch_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ADDR_LEN = addr_len(DEPTH),
    parameter int CNT_W    = cnt_w(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_valid,
    input  logic [WIDTH-1:0]    wr_data,
    output logic                wr_ready,
    input  logic                rd_req,
    input  logic [ADDR_LEN-1:0] rd_offset,
    output logic                rd_valid,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_err,
    input  logic                release_en,
    input  logic [CNT_W-1:0]    release_cnt,
    output logic [CNT_W-1:0]    count,
    output logic                full,
    output logic                empty
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ADDR_LEN-1:0] r_wr_ptr;
    logic [ADDR_LEN-1:0] r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic                r_rd_valid;
    logic                r_rd_err;
    logic [WIDTH-1:0]    r_rd_data;

    logic                w_full;
    logic                w_wr_fire;
    logic                w_rd_ok;
    logic                w_rd_bad;
    logic [CNT_W-1:0]    w_rel_amt;
    logic [ADDR_LEN-1:0] w_rel_inc;
    logic [ADDR_LEN-1:0] w_wr_ptr_nxt;
    logic [ADDR_LEN-1:0] w_rd_ptr_nxt;
    logic [ADDR_LEN-1:0] w_rd_addr;
    logic [CNT_W-1:0]    w_count_nxt;

    // Every decision below uses the pre-update state, so a write while full
    // stays rejected even when a release frees space on the same edge, and a
    // read can never reach the slot being written this cycle.
    assign w_full    = (r_count == DEPTH_CNT);
    assign w_wr_fire = wr_valid && !w_full;
    assign w_rd_ok   = rd_req && (CNT_W'(rd_offset) < r_count);
    assign w_rd_bad  = rd_req && !w_rd_ok;

    // Release is clamped to the occupancy rather than flagged as an error.
    assign w_rel_amt = !release_en             ? '0 :
                       (release_cnt < r_count) ? release_cnt : r_count;

    // Releasing a full window is a whole turn of the ring: pointer unchanged.
    // Any smaller amount is below DEPTH and fits the pointer width.
    assign w_rel_inc = (w_rel_amt == DEPTH_CNT) ? '0 : w_rel_amt[ADDR_LEN-1:0];

    assign w_count_nxt = r_count + CNT_W'(w_wr_fire) - w_rel_amt;

    ring_index_add #(.DEPTH(DEPTH), .ADDR_LEN(ADDR_LEN)) u_wr_inc (
        .i_base (r_wr_ptr),
        .i_inc  (ADDR_LEN'(1)),
        .o_sum  (w_wr_ptr_nxt)
    );

    ring_index_add #(.DEPTH(DEPTH), .ADDR_LEN(ADDR_LEN)) u_rel_adv (
        .i_base (r_rd_ptr),
        .i_inc  (w_rel_inc),
        .o_sum  (w_rd_ptr_nxt)
    );

    // An out-of-range offset may break the operand bound here; the result is
    // only consumed when the range check passes.
    ring_index_add #(.DEPTH(DEPTH), .ADDR_LEN(ADDR_LEN)) u_rd_addr (
        .i_base (r_rd_ptr),
        .i_inc  (rd_offset),
        .o_sum  (w_rd_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_data  <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= w_rd_ok;
            r_rd_err   <= w_rd_bad;
            // rd_data holds its last value on an out-of-range request.
            if (w_rd_ok) begin
                r_rd_data <= r_mem[w_rd_addr];
            end
        end
    end

    // Storage is deliberately not reset; flush leaves the contents intact.
    always_ff @(posedge clk) begin
        if (w_wr_fire && !flush && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign wr_ready = !w_full;
    assign full     = w_full;
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign rd_valid = r_rd_valid;
    assign rd_err   = r_rd_err;
    assign rd_data  = r_rd_data;

endmodule
